piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake. It accepts a WIDTH-bit word and emits it as WIDTH/LANES beats of LANES bits each, MSB-first or LSB-first, with frame and last-beat markers. It supports gapless back-to-back words. It sits between a parallel datapath and a narrow serial link, where it replaces the fixed 8-bit single-lane PISO register.

## Interface
- WIDTH, 8: parallel word width; must be a multiple of LANES and ≥ 2.
- LANES, 1: bits emitted per beat; 1 ≤ LANES ≤ WIDTH.
- MSB_FIRST, 1: 1 = most-significant beat first; 0 = least-significant beat first.
- Derived constant BEATS = WIDTH/LANES; beat counter width is max(1, clog2(BEATS)).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  word-valid request from upstream.
- din  input  WIDTH  parallel word; sampled only on an accepted load.
- ready  output  1  block can accept a word this cycle.
- dout  output  LANES  current serial beat.
- dout_valid  output  1  dout carries a valid beat.
- last  output  1  current beat is the final beat of the word.
- busy  output  1  a word is being shifted out (equals dout_valid).

## Operation
- States: IDLE and SHIFT.
- A word is accepted on a rising edge where load && ready is high. The shift register, lane order and beat counter are loaded on that edge.
- IDLE: ready=1, dout_valid=0, dout=0. An accepted load moves the block to SHIFT with beat_cnt=0.
- SHIFT: each cycle presents one beat, then beat_cnt increments on the next edge.
  - MSB_FIRST=1: beat k = din[WIDTH-1-k·LANES -: LANES]. dout[LANES-1] is the most significant bit of that slice.
  - MSB_FIRST=0: beat k = din[k·LANES +: LANES]. dout[0] is the least significant bit of that slice.
- last = dout_valid && (beat_cnt == BEATS-1).
- ready = (state==IDLE || last) && !reset. This is combinational from registered state. It must not depend on load.
- On the final beat:
  - If load is high, the next word is accepted. SHIFT continues with beat_cnt=0 and there is no idle gap.
  - Otherwise the block returns to IDLE.
- load while ready=0 is ignored. din is not sampled, and the current word continues undisturbed.
- BEATS=1 (LANES=WIDTH): every beat is last, ready stays 1 outside reset, and each accepted load yields exactly one beat.
- Reset (synchronous, has priority over load):
  - Shift register, beat_cnt, dout, dout_valid, last and busy all return to 0. State returns to IDLE.
  - ready is 0 while reset is high and 1 on the first cycle after reset deasserts.
  - Reset mid-frame discards the remaining beats. No partial last is emitted.
- dout is forced to 0 whenever dout_valid=0.

## Timing
- Latency: the first beat appears on dout in the cycle immediately after the accepting edge (one cycle).
- A word occupies exactly BEATS consecutive cycles of dout_valid=1.
- Throughput: one word per BEATS cycles when load is held high. There are no bubbles between words.
- dout, dout_valid, last and busy are registered or derived from registered state. Only ready includes the reset term combinationally.
- Output values after reset: dout=0, dout_valid=0, last=0, busy=0, ready=1 (once reset is low).

## Test plan
- WIDTH=8, LANES=1, MSB_FIRST=1; load 8'b11110011 for one cycle -> dout over 8 cycles = 1,1,1,1,0,0,1,1; last high only on the 8th beat; ready low on beats 1–7; then IDLE.
- WIDTH=8, LANES=1, MSB_FIRST=0; load 8'b01101101 -> dout = 1,0,1,1,0,1,1,0; dout_valid high for exactly 8 cycles.
- WIDTH=8, LANES=2, MSB_FIRST=1; load 8'hE7 -> dout = 2'b11, 2'b10, 2'b01, 2'b11; last on the 4th beat.
- Back-to-back, LANES=1, MSB_FIRST=1:
  - Hold load high with 8'hA5 and switch din to 8'h3C on the last beat -> 16 consecutive valid beats, 1010010100111100, with no gap.
  - Asserting load with 8'hFF during beats 1–7 is ignored and leaves the stream unchanged.
- Reset mid-frame, MSB_FIRST=1:
  - Load 8'b11100111 and assert reset after 4 beats (1,1,1,0) -> the next cycle has dout_valid=0, dout=0, last=0, and ready=0 during reset.
  - After reset deasserts: ready=1 and no further beats appear.
- LANES=WIDTH=8; load 8'h5A on three consecutive cycles -> three single-beat words 8'h5A, each with last=1; ready stays 1 throughout.

Source files
------------

// File: rtl/piso_if.sv
// Load-side handshake and serial-side outputs of the PISO serializer.
// The upstream/test side uses the master modport; the serializer uses the slave modport.
interface piso_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic [LANES-1:0] dout;
  logic             dout_valid;
  logic             last;
  logic             busy;

  modport master (
    output load, din,
    input  ready, dout, dout_valid, last, busy
  );

  modport slave (
    input  load, din,
    output ready, dout, dout_valid, last, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: emits a WIDTH-bit word as WIDTH/LANES beats,
// MSB- or LSB-first, and accepts the next word on the last beat so streams run gapless.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  piso_if.slave  bus
);
  localparam int BEATS = WIDTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic dout_valid;
  logic last;
  logic accept;

  assign dout_valid = (state_q == SHIFT);
  assign last       = dout_valid && (cnt_q == CW'(BEATS - 1));
  // Acceptance ignores reset here; the register block gives reset priority anyway.
  assign accept     = bus.load && ((state_q == IDLE) || last);

  assign bus.ready      = ((state_q == IDLE) || last) && !reset;
  assign bus.dout_valid = dout_valid;
  assign bus.busy       = dout_valid;
  assign bus.last       = last;
  assign bus.dout       = !dout_valid ? '0 :
                          (MSB_FIRST ? shreg_q[WIDTH-1 -: LANES] : shreg_q[LANES-1:0]);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = bus.din;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (last) begin
          if (accept) begin
            shreg_d = bus.din;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d = MSB_FIRST ? (shreg_q << LANES) : (shreg_q >> LANES);
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of the order the simulator runs processes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: four configurations checked one after another
// against hand-computed beat sequences.
module tb_piso_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r0, r1, r2, r3;
  int total = 0;
  int bad   = 0;

  piso_if #(.WIDTH(8), .LANES(1)) a_if ();
  piso_if #(.WIDTH(8), .LANES(1)) b_if ();
  piso_if #(.WIDTH(8), .LANES(2)) c_if ();
  piso_if #(.WIDTH(8), .LANES(8)) d_if ();

  piso_serializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_msb1 (.clk(clk), .reset(r0), .bus(a_if.slave));
  piso_serializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) u_lsb1 (.clk(clk), .reset(r1), .bus(b_if.slave));
  piso_serializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) u_msb2 (.clk(clk), .reset(r2), .bus(c_if.slave));
  piso_serializer #(.WIDTH(8), .LANES(8), .MSB_FIRST(1'b1)) u_wide (.clk(clk), .reset(r3), .bus(d_if.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp1 [8];
    int exp2 [8];
    int exp3 [4];
    int exp4 [16];
    int exp5 [8];
    int exp6 [4];

    exp1 = '{1, 1, 1, 1, 0, 0, 1, 1};                                  // 8'b11110011 MSB first
    exp2 = '{1, 0, 1, 1, 0, 1, 1, 0};                                  // 8'b01101101 LSB first
    exp3 = '{3, 2, 1, 3};                                              // 8'hE7, 2 lanes
    exp4 = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0};          // A5 then 3C
    exp5 = '{1, 0, 1, 0, 0, 1, 0, 1};                                  // 8'hA5 MSB first
    exp6 = '{1, 1, 1, 0};                                              // first 4 beats of E7

    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
    a_if.load = 1'b0; a_if.din = '0;
    b_if.load = 1'b0; b_if.din = '0;
    c_if.load = 1'b0; c_if.din = '0;
    d_if.load = 1'b0; d_if.din = '0;

    // Reset state
    step();
    step();
    check("rst_ready_a", a_if.ready, 0);
    check("rst_ready_d", d_if.ready, 0);
    check("rst_valid_a", a_if.dout_valid, 0);
    check("rst_dout_a", a_if.dout, 0);
    check("rst_last_a", a_if.last, 0);
    check("rst_busy_a", a_if.busy, 0);
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
    #1;
    check("post_rst_ready_a", a_if.ready, 1);
    check("post_rst_ready_b", b_if.ready, 1);
    check("post_rst_ready_c", c_if.ready, 1);
    check("post_rst_ready_d", d_if.ready, 1);

    // Single word, 1 lane, MSB first
    a_if.load = 1'b1; a_if.din = 8'b11110011;
    step();
    a_if.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t1_dout%0d", k), a_if.dout, exp1[k]);
      check($sformatf("t1_valid%0d", k), a_if.dout_valid, 1);
      check($sformatf("t1_last%0d", k), a_if.last, (k == 7) ? 1 : 0);
      check($sformatf("t1_ready%0d", k), a_if.ready, (k == 7) ? 1 : 0);
      step();
    end
    check("t1_idle_valid", a_if.dout_valid, 0);
    check("t1_idle_dout", a_if.dout, 0);
    check("t1_idle_ready", a_if.ready, 1);

    // Single word, 1 lane, LSB first
    b_if.load = 1'b1; b_if.din = 8'b01101101;
    step();
    b_if.load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t2_dout%0d", k), b_if.dout, exp2[k]);
      check($sformatf("t2_valid%0d", k), b_if.dout_valid, 1);
      step();
    end
    check("t2_idle_valid", b_if.dout_valid, 0);

    // Single word, 2 lanes, MSB first
    c_if.load = 1'b1; c_if.din = 8'hE7;
    step();
    c_if.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_dout%0d", k), c_if.dout, exp3[k]);
      check($sformatf("t3_last%0d", k), c_if.last, (k == 3) ? 1 : 0);
      step();
    end
    check("t3_idle_valid", c_if.dout_valid, 0);

    // Back-to-back words with load held high
    a_if.load = 1'b1; a_if.din = 8'hA5;
    step();
    for (int k = 0; k < 16; k++) begin
      if (k == 7) a_if.din = 8'h3C;
      if (k == 8) a_if.load = 1'b0;
      check($sformatf("t4_dout%0d", k), a_if.dout, exp4[k]);
      check($sformatf("t4_valid%0d", k), a_if.dout_valid, 1);
      check($sformatf("t4_last%0d", k), a_if.last, (k == 7 || k == 15) ? 1 : 0);
      step();
    end
    check("t4_idle_valid", a_if.dout_valid, 0);

    // Load during beats 1-7 is ignored
    a_if.load = 1'b1; a_if.din = 8'hA5;
    step();
    a_if.din = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) a_if.load = 1'b0;
      check($sformatf("t5_dout%0d", k), a_if.dout, exp5[k]);
      check($sformatf("t5_ready%0d", k), a_if.ready, (k == 7) ? 1 : 0);
      step();
    end
    a_if.load = 1'b0;
    check("t5_idle_valid", a_if.dout_valid, 0);
    check("t5_idle_dout", a_if.dout, 0);

    // Reset mid-frame discards the remaining beats
    a_if.load = 1'b1; a_if.din = 8'b11100111;
    step();
    a_if.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t6_dout%0d", k), a_if.dout, exp6[k]);
      if (k < 3) step();
    end
    r0 = 1'b1;
    #1;
    check("t6_ready_in_rst", a_if.ready, 0);
    step();
    check("t6_valid_rst", a_if.dout_valid, 0);
    check("t6_dout_rst", a_if.dout, 0);
    check("t6_last_rst", a_if.last, 0);
    check("t6_ready_rst", a_if.ready, 0);
    r0 = 1'b0;
    #1;
    check("t6_ready_after", a_if.ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t6_no_beat%0d", k), a_if.dout_valid, 0);
    end

    // Single-beat words (LANES == WIDTH), load held three cycles
    d_if.load = 1'b1; d_if.din = 8'h5A;
    check("t7_ready_pre", d_if.ready, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) d_if.load = 1'b0;
      check($sformatf("t7_dout%0d", k), d_if.dout, 8'h5A);
      check($sformatf("t7_valid%0d", k), d_if.dout_valid, 1);
      check($sformatf("t7_last%0d", k), d_if.last, 1);
      check($sformatf("t7_ready%0d", k), d_if.ready, 1);
      step();
    end
    check("t7_idle_valid", d_if.dout_valid, 0);
    check("t7_idle_ready", d_if.ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
